adam_axil_to_obi: RTL and testbench
===================================

ADAM_AXIL_TO_OBI -- requirements
Module: adam_axil_to_obi

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of both ports; strobe width STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have AXI-Lite write-address ports: aw_addr input ADDR_WIDTH, aw_valid input 1, aw_ready output 1.
REQ-006 SHALL have AXI-Lite write-data ports: w_data input DATA_WIDTH, w_strb input STRB_WIDTH, w_valid input 1, w_ready output 1.
REQ-007 SHALL have AXI-Lite write-response ports: b_resp output 2, b_valid output 1, b_ready input 1.
REQ-008 SHALL have AXI-Lite read-address ports: ar_addr input ADDR_WIDTH, ar_valid input 1, ar_ready output 1.
REQ-009 SHALL have AXI-Lite read-data ports: r_data output DATA_WIDTH, r_resp output 2, r_valid output 1, r_ready input 1.
REQ-010 SHALL have OBI request ports: req output 1, gnt input 1, addr output ADDR_WIDTH, we output 1, be output STRB_WIDTH, wdata output DATA_WIDTH.
REQ-011 SHALL have OBI response ports: rvalid input 1, rdata input DATA_WIDTH, err input 1; OBI rready is implicitly always 1.

Function
REQ-012 SHALL act as AXI-Lite responder and OBI initiator, with at most one transaction outstanding end to end.
REQ-013 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, RD_RSP, WR_REQ, WR_WAIT, WR_RSP.
REQ-014 IDLE: a read is eligible when ar_valid=1; a write is eligible only when aw_valid=1 and w_valid=1 in the same cycle.
REQ-015 IDLE arbitration: if only one is eligible, it wins; if both, the winner is chosen by a round-robin priority bit that toggles after each accepted transaction.
REQ-016 ar_ready SHALL equal (IDLE and read wins), and aw_ready = w_ready = (IDLE and write wins), all combinational; AW and W SHALL always be accepted in the same cycle.
REQ-017 On acceptance, SHALL register address, plus w_data/w_strb for writes, and move to RD_REQ or WR_REQ.
REQ-018 RD_REQ/WR_REQ: req=1 with registered addr; we=0 and be all-ones for reads; we=1, be=w_strb, wdata=w_data for writes; outputs SHALL be held stable until gnt=1, then go to RD_WAIT/WR_WAIT.
REQ-019 req SHALL be 0 in every state other than RD_REQ/WR_REQ; addr/we/be/wdata SHALL be 0 whenever req=0.
REQ-020 RD_WAIT/WR_WAIT: on rvalid=1, SHALL capture rdata (reads) and err, then go to RD_RSP/WR_RSP; rvalid in any other state SHALL be ignored.
REQ-021 RD_RSP: r_valid=1 with r_data=captured rdata and r_resp=2'b10 if err else 2'b00, held until r_ready=1, then return to IDLE.
REQ-022 WR_RSP: b_valid=1 with b_resp=2'b10 if err else 2'b00, held until b_ready=1, then return to IDLE.
REQ-023 Minimum latency, with gnt during the first req cycle and rvalid the next cycle: handshake at cycle 0, req at cycle 1, r_valid/b_valid at cycle 3; a new transaction can be accepted in the cycle after the response handshake.
REQ-024 A WSTRB of 0 SHALL still produce an OBI write with be=0 and a normal response.

Reset
REQ-025 While rst_ni=0, SHALL force state IDLE, priority bit to read-first, all internal registers to 0, and all outputs to 0 (ready outputs, req, r_valid, b_valid, data, resp).
REQ-026 Reset asserted mid-transaction SHALL abandon it immediately with no response issued; after release, operation SHALL begin from IDLE.

Verification
REQ-027 Single read: ar_addr=0x100, memory returns 0xDEADBEEF, gnt in the same cycle, rvalid next cycle -> req at cycle 1 with we=0, be=4'hF; r_valid at cycle 3 with r_data=0xDEADBEEF, r_resp=0.
REQ-028 Write with AW/W skew: aw_valid at cycle 0, w_valid at cycle 3, addr 0x40, data 0x12345678, strb 4'b0011 -> aw_ready and w_ready both assert only at cycle 3; OBI we=1, be=4'b0011; b_resp=0.
REQ-029 Simultaneous ar_valid and aw_valid+w_valid after reset, repeated 4 times -> order read, write, read, write.
REQ-030 Backpressure: gnt low for 5 cycles and r_ready low for 3 cycles -> req and addr stable for 6 cycles; r_valid/r_data stable until r_ready; no second ar_ready during the transaction.
REQ-031 Error: err=1 with rvalid on a write -> b_resp=2'b10; next read with err=0 -> r_resp=0.
REQ-032 Reset in RD_WAIT: after release, no r_valid; a subsequent read completes normally with r_resp=0.

Source files
------------

// File: rtl/adam_axil_to_obi.sv
// rtl/adam_axil_to_obi.sv - AXI-Lite responder to OBI initiator bridge, one transaction in flight.
module adam_axil_to_obi #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [STRB_WIDTH-1:0] w_strb,
  input  logic                  w_valid,
  output logic                  w_ready,
  output logic [1:0]            b_resp,
  output logic                  b_valid,
  input  logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic                  req,
  input  logic                  gnt,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  we,
  output logic [STRB_WIDTH-1:0] be,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rvalid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  err
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_RSP, WR_REQ, WR_WAIT, WR_RSP
  } state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;  // 0: read wins a tie, 1: write wins
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic rd_elig, wr_elig, rd_win, wr_win;

  assign rd_elig = ar_valid;
  assign wr_elig = aw_valid && w_valid;
  assign rd_win  = rd_elig && (!wr_elig || !prio_q);
  assign wr_win  = wr_elig && !rd_win;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ar_ready = 1'b0;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    b_resp   = 2'b00;
    r_valid  = 1'b0;
    r_resp   = 2'b00;
    r_data   = '0;
    req      = 1'b0;
    addr     = '0;
    we       = 1'b0;
    be       = '0;
    wdata    = '0;

    unique case (state_q)
      IDLE: begin
        // Readies are combinational from the valids, so keep them low while reset is held.
        if (rst_ni && rd_win) begin
          ar_ready = 1'b1;
          addr_d   = ar_addr;
          prio_d   = ~prio_q;
          state_d  = RD_REQ;
        end else if (rst_ni && wr_win) begin
          aw_ready = 1'b1;
          w_ready  = 1'b1;
          addr_d   = aw_addr;
          wdata_d  = w_data;
          strb_d   = w_strb;
          prio_d   = ~prio_q;
          state_d  = WR_REQ;
        end
      end
      RD_REQ: begin
        req  = 1'b1;
        addr = addr_q;
        be   = '1;
        if (gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = err;
          state_d = RD_RSP;
        end
      end
      RD_RSP: begin
        r_valid = 1'b1;
        r_data  = rdata_q;
        r_resp  = err_q ? 2'b10 : 2'b00;
        if (r_ready) state_d = IDLE;
      end
      WR_REQ: begin
        req   = 1'b1;
        addr  = addr_q;
        we    = 1'b1;
        be    = strb_q;
        wdata = wdata_q;
        if (gnt) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (rvalid) begin
          err_d   = err;
          state_d = WR_RSP;
        end
      end
      WR_RSP: begin
        b_valid = 1'b1;
        b_resp  = err_q ? 2'b10 : 2'b00;
        if (b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_adam_axil_to_obi.sv
// tb/tb_adam_axil_to_obi.sv - directed self-checking bench for adam_axil_to_obi.
module tb_adam_axil_to_obi;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] aw_addr, w_data, ar_addr, r_data, addr, wdata, rdata;
  logic [3:0]  w_strb, be;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [1:0]  b_resp, r_resp;
  logic        req, gnt, we, rvalid, err;

  int vectors = 0;
  int miscompares = 0;

  adam_axil_to_obi dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .req(req), .gnt(gnt), .addr(addr), .we(we), .be(be), .wdata(wdata),
    .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    aw_addr = '0; w_data = '0; w_strb = '0; ar_addr = '0; rdata = '0;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    b_ready = 1'b0; r_ready = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0;

    // Reset holds every output low even with all valids asserted.
    cyc(); #2;
    chk("rst_ar_ready", 32'(ar_ready), 0);
    chk("rst_aw_ready", 32'(aw_ready), 0);
    chk("rst_w_ready", 32'(w_ready), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_r_valid", 32'(r_valid), 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    cyc(); aw_valid = 0; w_valid = 0; ar_valid = 0; rst_ni = 1'b1;

    // Single read, minimum latency.
    cyc(); ar_addr = 32'h100; ar_valid = 1; #2;
    chk("rd_ar_ready", 32'(ar_ready), 1);
    chk("rd_aw_ready", 32'(aw_ready), 0);
    cyc(); ar_valid = 0; gnt = 1; #2;
    chk("rd_req", 32'(req), 1);
    chk("rd_addr", addr, 32'h100);
    chk("rd_we", 32'(we), 0);
    chk("rd_be", 32'(be), 32'hF);
    cyc(); gnt = 0; rvalid = 1; rdata = 32'hDEADBEEF; #2;
    chk("rd_req_off", 32'(req), 0);
    chk("rd_addr_off", addr, 0);
    chk("rd_r_valid_early", 32'(r_valid), 0);
    cyc(); rvalid = 0; rdata = 0; r_ready = 1; #2;
    chk("rd_r_valid", 32'(r_valid), 1);
    chk("rd_r_data", r_data, 32'hDEADBEEF);
    chk("rd_r_resp", 32'(r_resp), 0);
    cyc(); r_ready = 0; #2;
    chk("rd_r_valid_done", 32'(r_valid), 0);

    // Write with AW leading W by three cycles.
    cyc(); aw_addr = 32'h40; aw_valid = 1; #2;
    chk("sk_aw_ready_c0", 32'(aw_ready), 0);
    cyc(); #2;
    chk("sk_w_ready_c1", 32'(w_ready), 0);
    cyc(); #2;
    chk("sk_aw_ready_c2", 32'(aw_ready), 0);
    cyc(); w_data = 32'h12345678; w_strb = 4'b0011; w_valid = 1; #2;
    chk("sk_aw_ready_c3", 32'(aw_ready), 1);
    chk("sk_w_ready_c3", 32'(w_ready), 1);
    cyc(); aw_valid = 0; w_valid = 0; gnt = 1; #2;
    chk("sk_req", 32'(req), 1);
    chk("sk_we", 32'(we), 1);
    chk("sk_be", 32'(be), 32'h3);
    chk("sk_addr", addr, 32'h40);
    chk("sk_wdata", wdata, 32'h12345678);
    cyc(); gnt = 0; rvalid = 1; #2;
    cyc(); rvalid = 0; b_ready = 1; #2;
    chk("sk_b_valid", 32'(b_valid), 1);
    chk("sk_b_resp", 32'(b_resp), 0);
    cyc(); b_ready = 0; #2;
    chk("sk_b_valid_done", 32'(b_valid), 0);

    // Contention after reset alternates read, write, read, write.
    cyc(); rst_ni = 1'b0;
    cyc(); rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); ar_valid = 1; aw_valid = 1; w_valid = 1; ar_addr = 32'h10 + 32'(i); aw_addr = 32'h20 + 32'(i); w_strb = 4'hF; #2;
      chk("rr_ar_ready", 32'(ar_ready), 32'((i + 1) % 2));
      chk("rr_aw_ready", 32'(aw_ready), 32'(i % 2));
      cyc(); gnt = 1; #2;
      chk("rr_we", 32'(we), 32'(i % 2));
      cyc(); gnt = 0; rvalid = 1; #2;
      cyc(); rvalid = 0; r_ready = 1; b_ready = 1; ar_valid = 0; aw_valid = 0; w_valid = 0; #2;
      chk("rr_r_valid", 32'(r_valid), 32'((i + 1) % 2));
      chk("rr_b_valid", 32'(b_valid), 32'(i % 2));
    end
    cyc(); r_ready = 0; b_ready = 0;

    // Grant withheld for 5 cycles, response ignored in RD_RSP, r_ready withheld for 3 cycles.
    cyc(); ar_addr = 32'h200; ar_valid = 1; #2;
    chk("bp_ar_ready", 32'(ar_ready), 1);
    for (int i = 0; i < 6; i++) begin
      cyc(); gnt = (i == 5); #2;
      chk("bp_req", 32'(req), 1);
      chk("bp_addr", addr, 32'h200);
      chk("bp_ar_ready_busy", 32'(ar_ready), 0);
    end
    cyc(); gnt = 0; rvalid = 1; rdata = 32'hCAFEF00D; #2;
    chk("bp_req_off", 32'(req), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); rvalid = (i == 0); rdata = 32'h00000BAD; #2;
      chk("bp_r_valid", 32'(r_valid), 1);
      chk("bp_r_data", r_data, 32'hCAFEF00D);
      chk("bp_ar_ready_rsp", 32'(ar_ready), 0);
    end
    cyc(); r_ready = 1; ar_valid = 0; #2;
    chk("bp_r_valid_hs", 32'(r_valid), 1);
    cyc(); r_ready = 0; #2;
    chk("bp_r_valid_done", 32'(r_valid), 0);

    // Erroring write with zero strobe, then a clean read.
    cyc(); aw_addr = 32'h80; w_data = 32'h0; w_strb = 4'h0; aw_valid = 1; w_valid = 1; #2;
    chk("er_aw_ready", 32'(aw_ready), 1);
    cyc(); aw_valid = 0; w_valid = 0; gnt = 1; #2;
    chk("er_we", 32'(we), 1);
    chk("er_be", 32'(be), 0);
    cyc(); gnt = 0; rvalid = 1; err = 1; #2;
    cyc(); rvalid = 0; err = 0; b_ready = 1; #2;
    chk("er_b_valid", 32'(b_valid), 1);
    chk("er_b_resp", 32'(b_resp), 32'h2);
    cyc(); b_ready = 0; ar_addr = 32'h84; ar_valid = 1; #2;
    chk("er_ar_ready", 32'(ar_ready), 1);
    cyc(); ar_valid = 0; gnt = 1; #2;
    cyc(); gnt = 0; rvalid = 1; rdata = 32'h000055AA; #2;
    cyc(); rvalid = 0; r_ready = 1; #2;
    chk("er_r_valid", 32'(r_valid), 1);
    chk("er_r_resp", 32'(r_resp), 0);
    chk("er_r_data", r_data, 32'h000055AA);
    cyc(); r_ready = 0;

    // Reset while in RD_WAIT abandons the read; a late rvalid in IDLE is ignored.
    cyc(); ar_addr = 32'h300; ar_valid = 1; #2;
    cyc(); ar_valid = 0; gnt = 1; #2;
    cyc(); gnt = 0; rst_ni = 1'b0; #2;
    chk("rw_rst_req", 32'(req), 0);
    chk("rw_rst_r_valid", 32'(r_valid), 0);
    cyc(); rst_ni = 1'b1; rvalid = 1; rdata = 32'hFFFFFFFF; r_ready = 1; #2;
    for (int i = 0; i < 3; i++) begin
      cyc(); rvalid = 0; #2;
      chk("rw_no_r_valid", 32'(r_valid), 0);
    end
    cyc(); r_ready = 0; ar_addr = 32'h304; ar_valid = 1; #2;
    chk("rw_ar_ready", 32'(ar_ready), 1);
    cyc(); ar_valid = 0; gnt = 1; #2;
    chk("rw_addr", addr, 32'h304);
    cyc(); gnt = 0; rvalid = 1; rdata = 32'h1234ABCD; #2;
    cyc(); rvalid = 0; r_ready = 1; #2;
    chk("rw_r_valid", 32'(r_valid), 1);
    chk("rw_r_resp", 32'(r_resp), 0);
    chk("rw_r_data", r_data, 32'h1234ABCD);
    cyc(); r_ready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
